// File: rtl/alu_result_buffer.sv
// Registered result FIFO behind the 8-bit function units: stores result, opcode tag
// and status flags computed at write time, and presents the head through valid/ready.

module alu_rb_slot #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;

  // Storage is intentionally not reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (we) q_q <= d;
  end

  assign q = q_q;
endmodule

module alu_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_result,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_result,
  output logic [2:0]                 out_op,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_parity,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0] result;
    logic [2:0] op;
    logic       zero;
    logic       neg;
    logic       parity;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0][EW-1:0] slot_q;
  entry_t                   wr_entry;
  entry_t                   head;
  logic                     push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  // Flush wins over any handshake in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_entry        = '0;
    wr_entry.result = in_result;
    wr_entry.op     = in_op;
    wr_entry.zero   = (in_result == 8'h00);
    wr_entry.neg    = in_result[7];
    wr_entry.parity = ^in_result;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    alu_rb_slot #(.W(EW)) u_slot (
      .clk (clk),
      .we  (push && (wr_ptr_q == PW'(g))),
      .d   (wr_entry),
      .q   (slot_q[g])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty buffer presents all-zero data so stale slots never leak out.
  always_comb begin
    head = '0;
    if (out_valid) head = entry_t'(slot_q[rd_ptr_q]);
  end

  assign out_result = head.result;
  assign out_op     = head.op;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_parity = head.parity;
  assign count      = count_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: queue model checked every cycle plus literal pins.

module tb_alu_result_buffer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_result = 8'h00;
  logic [2:0] in_op = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic       out_zero, out_neg, out_parity;
  logic [2:0] count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] res;
    logic [2:0] op;
  } item_t;

  item_t mq[$];

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue with the handshake rules applied to its own size.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      bit do_pop, do_push;
      item_t it;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() != DEPTH);
      it.res = in_result;
      it.op  = in_op;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(it);
    end
  end

  always @(negedge clk) begin
    int sz;
    logic [7:0] r;
    logic [2:0] o;
    sz = mq.size();
    r  = (sz != 0) ? mq[0].res : 8'h00;
    o  = (sz != 0) ? mq[0].op : 3'd0;
    chk("m_count", int'(count), sz);
    chk("m_in_ready", int'(in_ready), int'(sz != DEPTH));
    chk("m_out_valid", int'(out_valid), int'(sz != 0));
    chk("m_out_result", int'(out_result), int'(r));
    chk("m_out_op", int'(out_op), int'(o));
    chk("m_out_zero", int'(out_zero), (sz != 0) ? int'(r == 8'h00) : 0);
    chk("m_out_neg", int'(out_neg), int'(r[7]));
    chk("m_out_parity", int'(out_parity), $countones(r) % 2);
  end

  task automatic cyc(input logic iv, input logic [7:0] ir, input logic [2:0] io,
                     input logic ordy, input logic fl);
    in_valid  = iv;
    in_result = ir;
    in_op     = io;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_v[4];
    logic       fill_p[4];
    logic       fill_n[4];
    logic [7:0] seq[12];

    fill_v = '{8'h81, 8'h7F, 8'h01, 8'hFF};
    fill_p = '{1'b0, 1'b1, 1'b1, 1'b0};
    fill_n = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    #2 rst_n = 1'b1;
    #1;

    // Single zero push
    cyc(1, 8'h00, 3'd5, 0, 0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_result", int'(out_result), 0);
    chk("single_op", int'(out_op), 5);
    chk("single_zero", int'(out_zero), 1);
    chk("single_neg", int'(out_neg), 0);
    chk("single_parity", int'(out_parity), 0);
    chk("single_count", int'(count), 1);
    cyc(0, 8'h00, 3'd0, 1, 0);
    chk("single_drained", int'(count), 0);

    // Fill, refuse fifth, drain in order
    for (int i = 0; i < 4; i++) cyc(1, fill_v[i], 3'(i), 0, 0);
    chk("fill_count", int'(count), 4);
    chk("fill_in_ready", int'(in_ready), 0);
    cyc(1, 8'h55, 3'd7, 0, 0);
    chk("fill_fifth_refused", int'(count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_result", int'(out_result), int'(fill_v[i]));
      chk("drain_op", int'(out_op), i);
      chk("drain_parity", int'(out_parity), int'(fill_p[i]));
      chk("drain_neg", int'(out_neg), int'(fill_n[i]));
      chk("drain_zero", int'(out_zero), 0);
      cyc(0, 8'h00, 3'd0, 1, 0);
    end
    chk("drain_empty", int'(out_valid), 0);

    // Streaming at count 2, pointers wrap
    seq[0] = 8'hA1;
    seq[1] = 8'hA2;
    for (int i = 0; i < 10; i++) seq[i+2] = 8'h10 + 8'(i);
    cyc(1, seq[0], 3'd1, 0, 0);
    cyc(1, seq[1], 3'd2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_count", int'(count), 2);
      chk("stream_result", int'(out_result), int'(seq[i]));
      cyc(1, seq[i+2], 3'(i), 1, 0);
    end
    chk("stream_head_after", int'(out_result), int'(seq[10]));
    cyc(0, 8'h00, 3'd0, 1, 0);
    cyc(0, 8'h00, 3'd0, 1, 0);
    chk("stream_empty", int'(count), 0);

    // Full plus pop: push refused
    for (int i = 0; i < 4; i++) cyc(1, 8'h30 + 8'(i), 3'(i), 0, 0);
    cyc(1, 8'h66, 3'd6, 1, 0);
    chk("fullpop_count", int'(count), 3);
    chk("fullpop_in_ready", int'(in_ready), 1);
    chk("fullpop_head", int'(out_result), 8'h31);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 3'd0, 1, 0);

    // Flush at count 3 with push and pop
    for (int i = 0; i < 3; i++) cyc(1, 8'hC0 + 8'(i), 3'(i), 0, 0);
    cyc(1, 8'hEE, 3'd3, 1, 1);
    chk("flush_count", int'(count), 0);
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_result", int'(out_result), 0);
    chk("flush_op", int'(out_op), 0);
    chk("flush_flags", int'({out_zero, out_neg, out_parity}), 0);

    // Async reset mid-stream
    cyc(1, 8'h11, 3'd1, 0, 0);
    cyc(1, 8'h22, 3'd2, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", int'(count), 0);
    chk("areset_valid", int'(out_valid), 0);
    chk("areset_in_ready", int'(in_ready), 1);
    chk("areset_result", int'(out_result), 0);
    chk("areset_op", int'(out_op), 0);
    #4 rst_n = 1'b1;
    cyc(1, 8'hA5, 3'd4, 0, 0);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_result", int'(out_result), 8'hA5);
    chk("post_rst_parity", int'(out_parity), 0);
    chk("post_rst_neg", int'(out_neg), 1);
    cyc(0, 8'h00, 3'd0, 1, 0);
    chk("post_rst_empty", int'(count), 0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage that sits directly downstream of the 8-bit function units (XOR8 and siblings). It captures each 8-bit result together with its opcode tag and derived status flags into a small FIFO. It presents them to the consumer through a valid/ready handshake, which decouples the combinational ALU from a stalling consumer.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  producer has a result this cycle
- in_ready  out  1  buffer can accept (not full)
- in_result  in  8  result word from function unit
- in_op  in  3  opcode tag of the producing operation
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer accepts head entry
- out_result  out  8  head result
- out_op  out  3  head opcode tag
- out_zero  out  1  head result == 8'h00
- out_neg  out  1  head result bit 7
- out_parity  out  1  XOR-reduction of head result (1 = odd number of ones)
- count  out  log2(DEPTH)+1  number of stored entries, 0..DEPTH

## Operation
- Push occurs when in_valid && in_ready at a clk edge. The entry stores in_result, in_op and the flags computed from in_result at write time.
- Pop occurs when out_valid && out_ready at a clk edge. The head advances.
- in_ready = (count != DEPTH). It depends only on registered state and never on out_ready.
- out_valid = (count != 0).
- Push and pop in the same cycle (only possible when 0 < count < DEPTH): count is unchanged, and both pointers advance.
- Full (count == DEPTH): in_ready = 0, and in_valid is ignored even if a pop happens that cycle. in_ready rises the cycle after the pop.
- Empty (count == 0): out_valid = 0. out_result, out_op and all flags are forced to 0. There is no write-through bypass.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Entries leave strictly in arrival order. Result and tag pass through bit-exact, and flags always match their own entry.
- Flush: on a clk edge with flush = 1, pointers and count go to 0. Any push or pop that cycle is discarded, so flush has priority.
- The producer must hold in_result and in_op stable while in_valid && !in_ready. The buffer does not check this.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately):
  - count = 0, pointers = 0
  - out_valid = 0, in_ready = 1
  - out_result/out_op/out_zero/out_neg/out_parity = 0
  - Storage contents need not be cleared.
- Reset release is synchronous to clk. The first push is accepted on the first clk edge after rst_n rises.
- Latency: an entry pushed at edge k is presented with out_valid = 1 after edge k. It is consumable at edge k+1 at the earliest.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- All outputs are driven from registered state through combinational decode only. There is no combinational path from in_* or out_ready to any output.
- Reset asserted mid-transfer discards all entries. No partial entry is ever presented.

## Test plan
- Reset then single push: in_result = 8'h00, in_op = 3'd5 → next cycle out_valid = 1, out_result = 8'h00, out_op = 5, out_zero = 1, out_neg = 0, out_parity = 0, count = 1.
- Fill with out_ready = 0: push 8'h81, 8'h7F, 8'h01, 8'hFF (DEPTH 4).
  - count = 4 and in_ready = 0; a fifth in_valid with 8'h55 is not stored.
  - Drain yields 81/7F/01/FF in order, with parity 0/1/1/0, neg 1/0/0/1 and zero 0 throughout.
- Simultaneous push/pop at count = 2 for 10 cycles (pointers wrap twice): count stays 2, and the output sequence equals the input sequence delayed by 2 entries.
- Full plus pop in the same cycle: count = 4, out_ready = 1, in_valid = 1 → the pop succeeds and the push is refused. Next cycle count = 3 and in_ready = 1.
- Flush with push and pop asserted at count = 3: next cycle count = 0, out_valid = 0, and all data/flag outputs are 0.
- Async reset pulse mid-stream at count = 2: all outputs return to reset values immediately, without a clk edge. The subsequent push of 8'hA5 emerges alone with parity 0 and neg 1.
